// File: rtl/ir_byte_fetcher.sv
// rtl/ir_byte_fetcher.sv - fetches a 32-bit instruction word as four byte reads into IR byte lanes
module ir_byte_fetcher #(
    parameter int BYTE_ORDER = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_busy_o,
    output logic        fetch_done_o,
    output logic        fetch_err_o,
    output logic        mem_rd_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [7:0]  ir_byte_o,
    output logic [3:0]  ir_write_o,
    output logic [15:0] fetch_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  iss_idx_q, iss_idx_d;
    logic [1:0]  ret_idx_q;
    logic        ret_vld_q;
    logic [31:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic [15:0] count_q;
    logic [1:0]  lane;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            iss_idx_q <= 2'd0;
            ret_idx_q <= 2'd0;
            ret_vld_q <= 1'b0;
            addr_q    <= 32'd0;
            err_q     <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            iss_idx_q <= iss_idx_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            // Read data returns one cycle after issue, so the return side trails the issue index
            ret_vld_q <= (state_q == ISSUE);
            ret_idx_q <= iss_idx_q;
            if (state_q == LAST) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        iss_idx_d  = iss_idx_q;
        addr_d     = addr_q;
        err_d      = 1'b0;
        mem_rd_o   = 1'b0;
        mem_addr_o = 32'd0;
        case (state_q)
            IDLE: begin
                if (fetch_req_i) begin
                    if (fetch_addr_i[1:0] == 2'b00) begin
                        addr_d    = fetch_addr_i;
                        iss_idx_d = 2'd0;
                        state_d   = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                mem_rd_o   = 1'b1;
                // Low bits come from the index alone, so the word base never carries
                mem_addr_o = {addr_q[31:2], iss_idx_q};
                iss_idx_d  = iss_idx_q + 2'd1;
                if (iss_idx_q == 2'd3) begin
                    state_d = LAST;
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lane          = (BYTE_ORDER != 0) ? ~ret_idx_q : ret_idx_q;
    assign ir_write_o    = ret_vld_q ? (4'b0001 << lane) : 4'b0000;
    assign ir_byte_o     = ret_vld_q ? mem_rdata_i : 8'h00;
    assign fetch_busy_o  = (state_q != IDLE);
    assign fetch_done_o  = (state_q == LAST);
    assign fetch_err_o   = err_q;
    assign fetch_count_o = count_q;

endmodule

// File: doc/ir_byte_fetcher.md
IR_BYTE_FETCHER -- requirements
Module: ir_byte_fetcher

Interface
REQ-001 The block SHALL have parameter BYTE_ORDER, default 0, meaning 0: byte at A+k strobes ir_write_o[k]; 1: byte at A+k strobes ir_write_o[3-k].
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-005 The block SHALL have port fetch_req_i, input, 1 bit: fetch request from the control unit (fetch_en).
REQ-006 The block SHALL have port fetch_addr_i, input, 32 bits: byte address of the instruction word (PC/Adr).
REQ-007 The block SHALL have port fetch_busy_o, output, 1 bit: fetch in progress.
REQ-008 The block SHALL have port fetch_done_o, output, 1 bit: one-cycle pulse, word fully delivered.
REQ-009 The block SHALL have port fetch_err_o, output, 1 bit: one-cycle pulse, misaligned request rejected.
REQ-010 The block SHALL have port mem_rd_o, output, 1 bit: byte-memory read strobe.
REQ-011 The block SHALL have port mem_addr_o, output, 32 bits: byte-memory read address.
REQ-012 The block SHALL have port mem_rdata_i, input, 8 bits: read byte, valid the cycle after mem_rd_o.
REQ-013 The block SHALL have port ir_byte_o, output, 8 bits: byte to the instruction register (instr8bit).
REQ-014 The block SHALL have port ir_write_o, output, 4 bits: one-hot IR byte-lane write strobe (IRWrite).
REQ-015 The block SHALL have port fetch_count_o, output, 16 bits: number of completed fetches.

Function
REQ-016 The block SHALL implement states IDLE, ISSUE, LAST, driven by a 2-bit issue index and a 2-bit return index.
REQ-017 In IDLE, fetch_req_i=1 with fetch_addr_i[1:0]=0 SHALL latch A=fetch_addr_i and move to ISSUE at the next edge (acceptance edge E0).
REQ-018 In IDLE, fetch_req_i=1 with fetch_addr_i[1:0]!=0 SHALL pulse fetch_err_o for the following cycle, issue no reads, and remain in IDLE.
REQ-019 Cycles after E0 SHALL behave as follows.
  - Cycles 1-4: mem_rd_o=1, mem_addr_o={A[31:2],k} for k=0..3.
  - Cycles 2-5: ir_write_o strobes the lane for byte k-1 per BYTE_ORDER.
  - Cycle 5: state LAST, mem_rd_o=0.
REQ-020 fetch_done_o SHALL be 1 in cycle 5 only, coincident with the last byte strobe; the state SHALL return to IDLE at the end of cycle 5.
REQ-021 fetch_busy_o SHALL be 1 in cycles 1-5 inclusive and 0 in IDLE.
REQ-022 The next request SHALL be accepted no earlier than cycle 6, giving a fetch-to-fetch minimum of 6 cycles.
REQ-023 ir_byte_o SHALL equal mem_rdata_i when any ir_write_o bit is set, else 8'h00; exactly one ir_write_o bit SHALL be set per strobe cycle.
REQ-024 fetch_req_i and fetch_addr_i SHALL be ignored while busy; A SHALL not change mid-fetch.
REQ-025 mem_addr_o SHALL be 0 when mem_rd_o=0.
REQ-026 A=32'hFFFFFFFC SHALL read FFFFFFFC..FFFFFFFF with no carry into A[31:2].
REQ-027 fetch_count_o SHALL increment on each fetch_done_o pulse and wrap from 16'hFFFF to 0; errors SHALL not count.
REQ-028 mem_rd_o, mem_addr_o, fetch_busy_o, fetch_done_o and fetch_err_o SHALL be registered or decoded from registered state only; ir_byte_o is the only path from mem_rdata_i.

Reset
REQ-029 rst_i=1 SHALL immediately force state IDLE, both indices 0, A=0 and fetch_count_o=0, and SHALL drive all other outputs to 0.
REQ-030 Reset asserted mid-fetch SHALL abort the fetch with no further strobes and no fetch_done_o; after release the block SHALL accept a new request normally.

Verification
REQ-031 Aligned fetch: BYTE_ORDER=0, req with addr 0x100, memory bytes 11,22,33,44 -> mem_addr 0x100..0x103 in cycles 1-4; ir_write 0001/0010/0100/1000 with bytes 11/22/33/44 in cycles 2-5; done in cycle 5; count=1.
REQ-032 Byte order: BYTE_ORDER=1, same stimulus -> ir_write 1000/0100/0010/0001 carrying 11/22/33/44.
REQ-033 Misaligned: req addr 0x102 -> fetch_err_o one cycle, mem_rd_o never 1, count unchanged, busy 0.
REQ-034 Back-to-back: req held high for 20 cycles at addr 0x0 -> acceptance every 6 cycles, 3 done pulses, addr change mid-fetch has no effect.
REQ-035 Reset mid-fetch: rst_i pulsed in cycle 3 -> outputs 0 immediately, no done, count 0; a new fetch at 0x200 completes correctly.
REQ-036 Wrap: addr 0xFFFFFFFC -> addresses FFFFFFFC..FFFFFFFF; count preloaded via 65535 fetches wraps to 0.
